// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory port between the I/D fill FSMs and D-cache
// write-through stores; drains in-flight reads after each fill.
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_miss,
  input  logic [15:0] ic_addr,
  input  logic        ic_done,
  input  logic        dc_miss,
  input  logic [15:0] dc_addr,
  input  logic        dc_done,
  input  logic        dc_wr_req,
  input  logic [15:0] dc_wr_addr,
  input  logic [15:0] dc_wr_data,
  input  logic        mem_data_valid,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic        ic_data_valid,
  output logic        dc_data_valid,
  output logic        dc_wr_ack,
  output logic        ic_stall,
  output logic        dc_stall
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GNT_I,
    S_GNT_D,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_fill;
  logic [CW-1:0]   r_drain_cnt;
  logic            w_ic_end;
  logic            w_dc_end;

  // A granted owner dropping its miss without done is treated like done.
  assign w_ic_end = ic_done | ~ic_miss;
  assign w_dc_end = dc_done | ~dc_miss;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_fill <= 1'b1;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_GNT_I: if (w_ic_end) begin
          r_last_fill <= 1'b0;
          r_drain_cnt <= CW'(MEM_LAT);
        end
        S_GNT_D: if (w_dc_end) begin
          r_last_fill <= 1'b1;
          r_drain_cnt <= CW'(MEM_LAT);
        end
        S_DRAIN: r_drain_cnt <= r_drain_cnt - CW'(1);
        default: r_drain_cnt <= '0;
      endcase
    end
  end

  // NOTE: defaults at the top of every always_comb keep it free of latches.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dc_wr_req)              w_next = S_WRITE;
        else if (ic_miss && dc_miss) w_next = r_last_fill ? S_GNT_I : S_GNT_D;
        else if (ic_miss)           w_next = S_GNT_I;
        else if (dc_miss)           w_next = S_GNT_D;
      end
      S_WRITE: w_next = S_IDLE;
      S_GNT_I: if (w_ic_end) w_next = S_DRAIN;
      S_GNT_D: if (w_dc_end) w_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == CW'(1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = 16'h0000;
    mem_data_in   = 16'h0000;
    ic_data_valid = 1'b0;
    dc_data_valid = 1'b0;
    dc_wr_ack     = 1'b0;
    case (r_state)
      S_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dc_wr_addr;
        mem_data_in = dc_wr_data;
        dc_wr_ack   = 1'b1;
      end
      S_GNT_I: begin
        mem_enable    = 1'b1;
        mem_addr      = ic_addr;
        ic_data_valid = mem_data_valid;
      end
      S_GNT_D: begin
        mem_enable    = 1'b1;
        mem_addr      = dc_addr;
        dc_data_valid = mem_data_valid;
      end
      default: ;
    endcase
  end

  assign ic_stall = ic_miss & (r_state != S_GNT_I);
  assign dc_stall = (dc_miss & (r_state != S_GNT_D)) | (dc_wr_req & ~dc_wr_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus hand-written
// fill, drain and reset sequences with a small latency memory model.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;
  localparam logic [15:0] IC_ADDR = 16'h1230;
  localparam logic [15:0] DC_ADDR = 16'h4560;
  localparam logic [15:0] WR_ADDR = 16'h00A4;
  localparam logic [15:0] WR_DATA = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_miss, ic_done, dc_miss, dc_done, dc_wr_req, mem_data_valid;
  logic [15:0] ic_addr, dc_addr, dc_wr_addr, dc_wr_data;
  logic [15:0] mem_addr, mem_data_in;
  logic        mem_enable, mem_wr, ic_data_valid, dc_data_valid, dc_wr_ack;
  logic        ic_stall, dc_stall;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_miss(ic_miss), .ic_addr(ic_addr), .ic_done(ic_done),
    .dc_miss(dc_miss), .dc_addr(dc_addr), .dc_done(dc_done),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .mem_data_valid(mem_data_valid),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .ic_data_valid(ic_data_valid), .dc_data_valid(dc_data_valid),
    .dc_wr_ack(dc_wr_ack), .ic_stall(ic_stall), .dc_stall(dc_stall)
  );

  always #5 clk = ~clk;

  // in6  = {ic_miss, ic_done, dc_miss, dc_done, dc_wr_req, mem_data_valid}
  // exp7 = {mem_enable, mem_wr, ic_data_valid, dc_data_valid, dc_wr_ack, ic_stall, dc_stall}
  typedef struct {
    logic [5:0]  in6;
    logic [6:0]  exp7;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {ic_miss, ic_done, dc_miss, dc_done, dc_wr_req, mem_data_valid} = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [6:0] ctl_now();
    return {mem_enable, mem_wr, ic_data_valid, dc_data_valid, dc_wr_ack, ic_stall, dc_stall};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MEM_LAT-1:0] pipe;
    int beats, first_en, done_cyc, d_gnt, stall_bad, drain_bad, leak, dcv_seen;
    logic rd;

    ic_addr    = IC_ADDR;
    dc_addr    = DC_ADDR;
    dc_wr_addr = WR_ADDR;
    dc_wr_data = WR_DATA;
    @(negedge clk);
    do_reset();

    #1;
    check("reset ctl",  32'(ctl_now()), 32'(7'b0000000));
    check("reset addr", 32'(mem_addr), 32'h0);
    check("reset data", 32'(mem_data_in), 32'h0);

    // Store/miss race, I fill with drain, D fill with a store held off, store, abnormal drop.
    vt.push_back('{6'b100010, 7'b0000011, 16'h0000, 16'h0000}); // IDLE: store + I miss
    vt.push_back('{6'b100010, 7'b1100110, WR_ADDR,  WR_DATA});  // WRITE
    vt.push_back('{6'b100000, 7'b0000010, 16'h0000, 16'h0000}); // IDLE
    vt.push_back('{6'b100001, 7'b1010000, IC_ADDR,  16'h0000}); // GNT_I beat
    vt.push_back('{6'b100000, 7'b1000000, IC_ADDR,  16'h0000});
    vt.push_back('{6'b111001, 7'b1010001, IC_ADDR,  16'h0000}); // I done, D waiting
    vt.push_back('{6'b001001, 7'b0000001, 16'h0000, 16'h0000}); // DRAIN x4, stale beats
    vt.push_back('{6'b001001, 7'b0000001, 16'h0000, 16'h0000});
    vt.push_back('{6'b001001, 7'b0000001, 16'h0000, 16'h0000});
    vt.push_back('{6'b001001, 7'b0000001, 16'h0000, 16'h0000});
    vt.push_back('{6'b101000, 7'b0000011, 16'h0000, 16'h0000}); // IDLE both: D (last was I)
    vt.push_back('{6'b111011, 7'b1001011, DC_ADDR,  16'h0000}); // GNT_D, foreign done, store
    vt.push_back('{6'b101110, 7'b1000011, DC_ADDR,  16'h0000}); // D done
    vt.push_back('{6'b100011, 7'b0000011, 16'h0000, 16'h0000}); // DRAIN x4, store waits
    vt.push_back('{6'b100011, 7'b0000011, 16'h0000, 16'h0000});
    vt.push_back('{6'b100011, 7'b0000011, 16'h0000, 16'h0000});
    vt.push_back('{6'b100011, 7'b0000011, 16'h0000, 16'h0000});
    vt.push_back('{6'b100010, 7'b0000011, 16'h0000, 16'h0000}); // IDLE: store wins
    vt.push_back('{6'b100010, 7'b1100110, WR_ADDR,  WR_DATA});  // WRITE
    vt.push_back('{6'b100000, 7'b0000010, 16'h0000, 16'h0000}); // IDLE
    vt.push_back('{6'b000000, 7'b1000000, IC_ADDR,  16'h0000}); // GNT_I, miss dropped
    vt.push_back('{6'b000001, 7'b0000000, 16'h0000, 16'h0000}); // DRAIN x4
    vt.push_back('{6'b000000, 7'b0000000, 16'h0000, 16'h0000});
    vt.push_back('{6'b000000, 7'b0000000, 16'h0000, 16'h0000});
    vt.push_back('{6'b000000, 7'b0000000, 16'h0000, 16'h0000});
    vt.push_back('{6'b001000, 7'b0000001, 16'h0000, 16'h0000}); // IDLE
    vt.push_back('{6'b001000, 7'b1000000, DC_ADDR,  16'h0000}); // GNT_D

    for (int i = 0; i < vt.size(); i++) begin
      {ic_miss, ic_done, dc_miss, dc_done, dc_wr_req, mem_data_valid} = vt[i].in6;
      #1;
      check($sformatf("vec%0d ctl", i),  32'(ctl_now()),   32'(vt[i].exp7));
      check($sformatf("vec%0d addr", i), 32'(mem_addr),    32'(vt[i].addr));
      check($sformatf("vec%0d data", i), 32'(mem_data_in), 32'(vt[i].data));
      tick();
    end

    // Reset for one cycle while GNT_D: aborts without a drain.
    {ic_miss, ic_done, dc_miss, dc_done, dc_wr_req, mem_data_valid} = 6'b001001;
    rst_n = 1'b0;
    #1;
    check("pre-reset gnt_d en", 32'(mem_enable), 32'h1);
    tick();
    rst_n = 1'b1;
    #1;
    check("post-reset en",    32'(mem_enable), 32'h0);
    check("post-reset dcv",   32'(dc_data_valid), 32'h0);
    check("post-reset stall", 32'(dc_stall), 32'h1);
    tick();
    #1;
    check("regrant d en",   32'(mem_enable), 32'h1);
    check("regrant d addr", 32'(mem_addr), 32'(DC_ADDR));

    // Simultaneous misses after reset with a latency-MEM_LAT memory model.
    do_reset();
    ic_miss = 1'b1;
    dc_miss = 1'b1;
    pipe = '0;
    beats = 0; first_en = -1; done_cyc = -1; d_gnt = -1;
    stall_bad = 0; drain_bad = 0; leak = 0; dcv_seen = 0;
    for (int c = 0; c < 60 && d_gnt < 0; c++) begin
      mem_data_valid = pipe[MEM_LAT-1];
      ic_done = (done_cyc < 0) && mem_data_valid && (beats == 7);
      #1;
      if (mem_enable && first_en < 0) first_en = c;
      if (ic_data_valid) beats++;
      if (dc_data_valid) dcv_seen++;
      if (c >= 1 && done_cyc < 0 && (ic_stall !== 1'b0 || dc_stall !== 1'b1)) stall_bad++;
      if (done_cyc >= 0 && c > done_cyc && c <= done_cyc + 5 && mem_enable) drain_bad++;
      if (done_cyc >= 0 && c > done_cyc && c <= done_cyc + MEM_LAT &&
          (ic_data_valid || dc_data_valid)) leak++;
      if (ic_done) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc && mem_enable && mem_addr == DC_ADDR) d_gnt = c;
      rd = mem_enable && !mem_wr && (mem_addr == IC_ADDR);
      tick();
      pipe = {pipe[MEM_LAT-2:0], rd};
      if (c == done_cyc) ic_miss = 1'b0;
    end
    check("fill first enable cycle", 32'(first_en), 32'd1);
    check("fill i done seen",        32'(done_cyc >= 0), 32'h1);
    check("fill i beats",            32'(beats), 32'd8);
    check("fill dc_data_valid count", 32'(dcv_seen), 32'd0);
    check("fill stall violations",   32'(stall_bad), 32'd0);
    check("drain enable violations", 32'(drain_bad), 32'd0);
    check("drain stale beat leaks",  32'(leak), 32'd0);
    check("d grant cycle after done", 32'(d_gnt - done_cyc), 32'd6);

    {ic_miss, ic_done, dc_miss, dc_done, dc_wr_req, mem_data_valid} = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
